// File: rtl/bitlet_pkg.sv
// Shared definitions for the Bitlet selection scheduler.
// Holds the sequencer state encoding, the default tile geometry, and the
// helpers that derive the select and counter widths from the tile length.
package bitlet_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_VEC_LENGTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of an activation index; a single-entry tile still needs one bit.
    function automatic int sel_width(input int vec_length);
        return (vec_length > 1) ? $clog2(vec_length) : 1;
    endfunction

    // Width able to hold 0..vec_length issue cycles.
    function automatic int cnt_width(input int vec_length);
        return $clog2(vec_length + 1);
    endfunction

endpackage

// File: rtl/bitlet_lane_picker.sv
// Combinational lowest-set-bit picker for one bit-significance lane.
// Ports:
//   mask   - pending activations for this lane (bit i = weight i has this bit set)
//   sel    - index of the lowest set bit, 0 when the mask is empty
//   any    - mask has at least one bit set
//   rest   - mask with its lowest set bit cleared
//   single - mask has at most one bit set (rest is empty)
module bitlet_lane_picker #(
    parameter int VEC_LENGTH = 32,
    parameter int SEL_WIDTH  = 5
) (
    input  logic [VEC_LENGTH-1:0] mask,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  any,
    output logic [VEC_LENGTH-1:0] rest,
    output logic                  single
);

    // Classic x & (x-1): drops exactly the lowest set bit.
    assign rest   = mask & (mask - VEC_LENGTH'(1));
    assign any    = |mask;
    assign single = ~|rest;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        sel = '0;
        for (int i = VEC_LENGTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel = SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/bitlet_sel_scheduler.sv
// Sequencer for the Bitlet bit-serial MAC.
// Accepts one tile of VEC_LENGTH weights, transposes it into one mask per bit
// lane, and each ISSUE cycle hands the MAC the lowest pending activation index
// per lane. A DRAIN cycle follows to flush the MAC psum pipeline register.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   w_valid/w_ready    - tile handshake; w_in and w_accum_init sampled on accept
//   stall              - freezes sequencing and forces mac_en low
//   act_sel/act_val    - per-lane activation index and valid (from registers only)
//   mac_en, load_accum - MAC controls
//   busy               - accept through DRAIN
//   done               - one-cycle pulse, MAC result valid
//   tile_cycles        - ISSUE cycle count of the last completed tile
module bitlet_sel_scheduler
    import bitlet_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int VEC_LENGTH = DEFAULT_VEC_LENGTH,
    parameter int SEL_WIDTH  = sel_width(VEC_LENGTH),
    parameter int CNT_WIDTH  = cnt_width(VEC_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_in [VEC_LENGTH],
    input  logic                  w_accum_init,
    input  logic                  stall,
    output logic [SEL_WIDTH-1:0]  act_sel [DATA_WIDTH],
    output logic                  act_val [DATA_WIDTH],
    output logic                  mac_en,
    output logic                  load_accum,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  tile_cycles
);

    state_t                 state_reg, state_next;
    logic                   init_q_reg;
    logic                   first_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [CNT_WIDTH-1:0]   tile_cycles_reg;
    logic                   done_reg;

    logic                   accept;
    logic                   issue_adv;
    logic                   drain_adv;
    logic [DATA_WIDTH-1:0]  pick_any;
    logic [DATA_WIDTH-1:0]  pick_single;
    logic [SEL_WIDTH-1:0]   pick_sel  [DATA_WIDTH];
    logic [VEC_LENGTH-1:0]  pick_rest [DATA_WIDTH];

    assign accept    = w_valid && (state_reg == IDLE);
    assign issue_adv = (state_reg == ISSUE) && !stall;
    assign drain_adv = (state_reg == DRAIN) && !stall;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_lane
        logic [VEC_LENGTH-1:0] w_col;
        logic [VEC_LENGTH-1:0] mask_reg;

        // Column gi of the tile: bit gi of every weight.
        for (genvar gj = 0; gj < VEC_LENGTH; gj++) begin : g_col
            assign w_col[gj] = w_in[gj][gi];
        end

        bitlet_lane_picker #(
            .VEC_LENGTH (VEC_LENGTH),
            .SEL_WIDTH  (SEL_WIDTH)
        ) u_picker (
            .mask   (mask_reg),
            .sel    (pick_sel[gi]),
            .any    (pick_any[gi]),
            .rest   (pick_rest[gi]),
            .single (pick_single[gi])
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mask_reg <= '0;
            end else if (accept) begin
                mask_reg <= w_col;
            end else if (issue_adv) begin
                mask_reg <= pick_rest[gi];
            end
        end

        // Only ISSUE presents selections; DRAIN and IDLE show an idle lane.
        assign act_val[gi] = (state_reg == ISSUE) && pick_any[gi];
        assign act_sel[gi] = (state_reg == ISSUE) ? pick_sel[gi] : '0;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (w_valid) state_next = ISSUE;
            // Leaving once every lane holds at most one bit means the clear on
            // this cycle empties all masks; an all-zero tile still gets one cycle.
            ISSUE: if (!stall && (&pick_single)) state_next = DRAIN;
            DRAIN: if (!stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        w_ready    = (state_reg == IDLE);
        busy       = (state_reg != IDLE);
        mac_en     = ((state_reg == ISSUE) || (state_reg == DRAIN)) && !stall;
        load_accum = (state_reg == ISSUE) && init_q_reg && first_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            init_q_reg      <= 1'b0;
            first_reg       <= 1'b0;
            cnt_reg         <= '0;
            tile_cycles_reg <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= drain_adv;
            if (accept) begin
                init_q_reg <= w_accum_init;
                first_reg  <= 1'b1;
                cnt_reg    <= '0;
            end else if (issue_adv) begin
                // load_accum stays up through stalls until the MAC takes it.
                first_reg <= 1'b0;
                cnt_reg   <= cnt_reg + CNT_WIDTH'(1);
            end
            if (drain_adv) begin
                tile_cycles_reg <= cnt_reg;
            end
        end
    end

    assign done        = done_reg;
    assign tile_cycles = tile_cycles_reg;

endmodule

// File: tb/tb_bitlet_sel_scheduler.sv
module tb_bitlet_sel_scheduler;

    localparam int DW = 8;
    localparam int VL = 32;
    localparam int SW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DW-1:0] w_in [VL];
    logic          w_accum_init = 1'b0;
    logic          stall = 1'b0;
    logic [SW-1:0] act_sel [DW];
    logic          act_val [DW];
    logic          mac_en;
    logic          load_accum;
    logic          busy;
    logic          done;
    logic [CW-1:0] tile_cycles;

    bitlet_sel_scheduler #(
        .DATA_WIDTH (DW),
        .VEC_LENGTH (VL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_in         (w_in),
        .w_accum_init (w_accum_init),
        .stall        (stall),
        .act_sel      (act_sel),
        .act_val      (act_val),
        .mac_en       (mac_en),
        .load_accum   (load_accum),
        .busy         (busy),
        .done         (done),
        .tile_cycles  (tile_cycles)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int load_seen = 0;

    typedef struct {
        bit       new_tile;
        bit       init;
        bit       stall;
        bit       mac_en;
        bit       load;
        bit       busy;
        bit       done;
        bit [7:0] val;
        int       sel0;
        int       sel7;
    } row_t;

    row_t rows [11];

    function automatic row_t mk(bit nt, bit in, bit st, bit me, bit ld, bit bz,
                                bit dn, bit [7:0] v, int s0, int s7);
        row_t r;
        r.new_tile = nt; r.init = in; r.stall = st; r.mac_en = me; r.load = ld;
        r.busy = bz; r.done = dn; r.val = v; r.sel0 = s0; r.sel7 = s7;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int vals();
        int v = 0;
        for (int b = 0; b < DW; b++) v |= int'(act_val[b]) << b;
        return v;
    endfunction

    function automatic int sel_or();
        int s = 0;
        for (int b = 0; b < DW; b++) s |= int'(act_sel[b]);
        return s;
    endfunction

    // kind 0: all zero, 1: all 8'h01, 2: w[5]=81, w[17]=80
    task automatic set_tile(input int kind);
        for (int i = 0; i < VL; i++) w_in[i] = (kind == 1) ? 8'h01 : 8'h00;
        if (kind == 2) begin
            w_in[5]  = 8'h81;
            w_in[17] = 8'h80;
        end
    endtask

    // Outputs are sampled 2 time units after the active edge.
    task automatic next_cycle(input logic s);
        @(posedge clk);
        #1 stall = s;
        #1;
    endtask

    task automatic accept_tile(input int kind, input logic init, input logic s);
        set_tile(kind);
        w_accum_init = init;
        w_valid = 1'b1;
        @(posedge clk);
        #1 w_valid = 1'b0;
        stall = s;
        #1;
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int r = first; r <= last; r++) begin
            if (rows[r].new_tile) accept_tile(2, rows[r].init, rows[r].stall);
            else next_cycle(rows[r].stall);
            if (load_accum) load_seen++;
            check($sformatf("%s r%0d mac_en", tag, r), int'(mac_en), int'(rows[r].mac_en));
            check($sformatf("%s r%0d load_accum", tag, r), int'(load_accum), int'(rows[r].load));
            check($sformatf("%s r%0d busy", tag, r), int'(busy), int'(rows[r].busy));
            check($sformatf("%s r%0d done", tag, r), int'(done), int'(rows[r].done));
            check($sformatf("%s r%0d act_val", tag, r), vals(), int'(rows[r].val));
            check($sformatf("%s r%0d sel0", tag, r), int'(act_sel[0]), rows[r].sel0);
            check($sformatf("%s r%0d sel7", tag, r), int'(act_sel[7]), rows[r].sel7);
            if (rows[r].done) begin
                check($sformatf("%s tile_cycles", tag), int'(tile_cycles), 2);
                $display("tile %s done tile_cycles=%0d", tag, tile_cycles);
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sparse tile, no stall (rows 0..3) and with stall in cycles 2..4 (rows 4..10).
        //            nt in st me ld bz dn  val    s0 s7
        rows[0]  = mk(1, 1, 0, 1, 1, 1, 0, 8'h81, 5, 5);
        rows[1]  = mk(0, 0, 0, 1, 0, 1, 0, 8'h80, 0, 17);
        rows[2]  = mk(0, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0);
        rows[3]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        rows[4]  = mk(1, 1, 0, 1, 1, 1, 0, 8'h81, 5, 5);
        rows[5]  = mk(0, 0, 1, 0, 0, 1, 0, 8'h80, 0, 17);
        rows[6]  = mk(0, 0, 1, 0, 0, 1, 0, 8'h80, 0, 17);
        rows[7]  = mk(0, 0, 1, 0, 0, 1, 0, 8'h80, 0, 17);
        rows[8]  = mk(0, 0, 0, 1, 0, 1, 0, 8'h80, 0, 17);
        rows[9]  = mk(0, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0);
        rows[10] = mk(0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0);

        set_tile(0);

        // Reset state
        #1;
        check("rst w_ready", int'(w_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst mac_en", int'(mac_en), 0);
        check("rst tile_cycles", int'(tile_cycles), 0);
        check("rst act_val", vals(), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // All weights 8'h01: lane 0 walks 0..31
        accept_tile(1, 1'b0, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            if (c > 1) next_cycle(1'b0);
            check($sformatf("t1 c%0d act_val", c), vals(), 1);
            check($sformatf("t1 c%0d sel0", c), int'(act_sel[0]), c - 1);
            check($sformatf("t1 c%0d mac_en", c), int'(mac_en), 1);
            check($sformatf("t1 c%0d load_accum", c), int'(load_accum), 0);
            check($sformatf("t1 c%0d w_ready", c), int'(w_ready), 0);
        end
        next_cycle(1'b0);
        check("t1 drain act_val", vals(), 0);
        check("t1 drain mac_en", int'(mac_en), 1);
        check("t1 drain busy", int'(busy), 1);
        check("t1 drain done", int'(done), 0);
        next_cycle(1'b0);
        check("t1 done", int'(done), 1);
        check("t1 tile_cycles", int'(tile_cycles), 32);
        check("t1 w_ready", int'(w_ready), 1);
        check("t1 busy", int'(busy), 0);
        $display("tile t1 done tile_cycles=%0d", tile_cycles);
        next_cycle(1'b0);
        check("t1 done pulse", int'(done), 0);

        // All-zero tile with accum_init
        accept_tile(0, 1'b1, 1'b0);
        check("t2 c1 load_accum", int'(load_accum), 1);
        check("t2 c1 mac_en", int'(mac_en), 1);
        check("t2 c1 act_val", vals(), 0);
        next_cycle(1'b0);
        check("t2 c2 load_accum", int'(load_accum), 0);
        check("t2 c2 mac_en", int'(mac_en), 1);
        check("t2 c2 done", int'(done), 0);
        next_cycle(1'b0);
        check("t2 c3 done", int'(done), 1);
        check("t2 tile_cycles", int'(tile_cycles), 1);
        $display("tile t2 done tile_cycles=%0d", tile_cycles);

        // Sparse tile, then same tile with stall
        run_rows(0, 3, "t3");
        load_seen = 0;
        run_rows(4, 10, "t4");
        check("t4 load_accum count", load_seen, 1);

        // Reset mid-tile in cycle 10 of the 8'h01 tile
        accept_tile(1, 1'b1, 1'b0);
        for (int c = 2; c <= 10; c++) next_cycle(1'b0);
        check("t5 pre act_sel", int'(act_sel[0]), 9);
        reset = 1'b1;
        #1;
        check("t5 rst act_val", vals(), 0);
        check("t5 rst act_sel", sel_or(), 0);
        check("t5 rst mac_en", int'(mac_en), 0);
        check("t5 rst load_accum", int'(load_accum), 0);
        check("t5 rst busy", int'(busy), 0);
        check("t5 rst done", int'(done), 0);
        check("t5 rst tile_cycles", int'(tile_cycles), 0);
        check("t5 rst w_ready", int'(w_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        load_seen = 0;
        run_rows(0, 3, "t5");
        check("t5 load_accum count", load_seen, 1);

        // w_valid held across two tiles: zero tile then sparse tile
        set_tile(0);
        w_accum_init = 1'b0;
        w_valid = 1'b1;
        @(posedge clk);
        #1 set_tile(2);
        #1;
        check("t6 c1 w_ready", int'(w_ready), 0);
        check("t6 c1 busy", int'(busy), 1);
        next_cycle(1'b0);
        check("t6 c2 w_ready", int'(w_ready), 0);
        check("t6 c2 done", int'(done), 0);
        next_cycle(1'b0);
        check("t6 c3 done", int'(done), 1);
        check("t6 c3 w_ready", int'(w_ready), 1);
        check("t6 c3 tile_cycles", int'(tile_cycles), 1);
        $display("tile t6a done tile_cycles=%0d", tile_cycles);
        @(posedge clk);
        #1 w_valid = 1'b0;
        #1;
        check("t6 c4 busy", int'(busy), 1);
        check("t6 c4 w_ready", int'(w_ready), 0);
        check("t6 c4 act_val", vals(), 8'h81);
        check("t6 c4 sel7", int'(act_sel[7]), 5);
        next_cycle(1'b0);
        check("t6 c5 sel7", int'(act_sel[7]), 17);
        next_cycle(1'b0);
        check("t6 c6 done", int'(done), 0);
        next_cycle(1'b0);
        check("t6 c7 done", int'(done), 1);
        check("t6 c7 tile_cycles", int'(tile_cycles), 2);
        $display("tile t6b done tile_cycles=%0d", tile_cycles);
        next_cycle(1'b0);
        check("t6 c8 busy", int'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
